// File: rtl/paz_pkg.sv
`default_nettype none
// ============================================================================
// Module   : paz_pkg
// Purpose  : Shared constants, direction codes and sequencer states for the
//            2x3 sliding-puzzle move controller. Optional: PAZ_UNDO_EN.
// Revision : 1.0 - initial release
// ============================================================================
package paz_pkg;

    localparam int BOARD_W   = 26;
    localparam int CELL_W    = 3;
    localparam int NUM_CELLS = 6;
    localparam int CELLS_W   = CELL_W * NUM_CELLS;

    localparam logic [4:0] REG_BOARD = 5'd0;
    localparam logic [4:0] REG_GOAL  = 5'd1;
    localparam logic [4:0] REG_DEPTH = 5'd2;
    localparam logic [4:0] REG_COMP  = 5'd30;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RD   = 4'd1,
`ifdef PAZ_UNDO_EN
        S_RD_M = 4'd2,
`endif
        S_CHK  = 4'd3,
        S_WR_B = 4'd4,
        S_WR_M = 4'd5,
        S_WR_D = 4'd6,
        S_CMP  = 4'd7,
        S_WR_C = 4'd8,
        S_FIN  = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/paz_move_calc.sv
`default_nettype none
// ============================================================================
// Module   : paz_move_calc
// Purpose  : Combinational blank search, move legality and blank/target swap.
// Revision : 1.0 - initial release
// ============================================================================
module paz_move_calc
    import paz_pkg::*;
(
    input  logic [CELLS_W-1:0] board,
    input  logic [1:0]         dir,
    output logic [CELLS_W-1:0] new_board,
    output logic               legal
);

    logic [CELL_W-1:0] w_cells [NUM_CELLS];
    logic [2:0]        w_blanks;
    logic [2:0]        w_pos;
    logic [2:0]        w_tgt;
    logic [CELL_W-1:0] w_tgt_val;
    logic              w_dir_ok;

    genvar gi;
    for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
        assign w_cells[gi] = board[gi*CELL_W +: CELL_W];
    end

    always_comb begin
        w_blanks = '0;
        w_pos    = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (w_cells[i] == '0) begin
                w_blanks = w_blanks + 3'd1;
                w_pos    = i[2:0];
            end
        end
    end

    // Positions 0/3 are column 0 and 2/5 are column 2 on the 2x3 grid.
    always_comb begin
        w_dir_ok = 1'b0;
        w_tgt    = w_pos;
        case (dir)
            DIR_UP: begin
                w_dir_ok = (w_pos >= 3'd3);
                w_tgt    = w_pos - 3'd3;
            end
            DIR_DOWN: begin
                w_dir_ok = (w_pos < 3'd3);
                w_tgt    = w_pos + 3'd3;
            end
            DIR_LEFT: begin
                w_dir_ok = (w_pos != 3'd0) && (w_pos != 3'd3);
                w_tgt    = w_pos - 3'd1;
            end
            default: begin
                w_dir_ok = (w_pos != 3'd2) && (w_pos != 3'd5);
                w_tgt    = w_pos + 3'd1;
            end
        endcase
    end

    assign legal = (w_blanks == 3'd1) && w_dir_ok;

    always_comb begin
        w_tgt_val = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (i[2:0] == w_tgt) begin
                w_tgt_val = w_cells[i];
            end
        end
    end

    always_comb begin
        new_board = board;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (i[2:0] == w_pos) begin
                new_board[i*CELL_W +: CELL_W] = w_tgt_val;
            end else if (i[2:0] == w_tgt) begin
                new_board[i*CELL_W +: CELL_W] = '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/paz_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : paz_move_ctrl
// Purpose  : Applies one puzzle move to the solver regfile. PAZ_UNDO_EN adds
//            an undo input that reverts the most recent recorded move.
// Revision : 1.0 - initial release
// ============================================================================
module paz_move_ctrl
    import paz_pkg::*;
#(
    parameter int MAX_DEPTH = 19,
    parameter int MOVE0     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         dir,
`ifdef PAZ_UNDO_EN
    input  logic               undo,
`endif
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic               solved,
    output logic [4:0]         depth_out,
    output logic [4:0]         rf_src0,
    output logic [4:0]         rf_src1,
    output logic [4:0]         rf_dst,
    output logic               rf_we,
    output logic [BOARD_W-1:0] rf_wdata,
    input  logic [BOARD_W-1:0] rf_data0,
    input  logic [BOARD_W-1:0] rf_data1
);

    localparam logic [4:0] C_MAX_DEPTH = 5'(MAX_DEPTH);
    localparam logic [4:0] C_MOVE0     = 5'(MOVE0);

    state_t             r_state;
    logic [1:0]         r_dir;
    logic [CELLS_W-1:0] r_board;
    logic [4:0]         r_depth;

    logic               w_undo;
    logic               w_legal;
    logic               w_depth_ok;
    logic [CELLS_W-1:0] w_new_board;
    logic [4:0]         w_depth_nxt;
    logic [4:0]         w_slot;
    logic               w_unused;

`ifdef PAZ_UNDO_EN
    logic               r_undo;
    assign w_undo = r_undo;
`else
    assign w_undo = 1'b0;
`endif

    assign w_unused = &{1'b0, rf_data0[BOARD_W-1:CELLS_W], rf_data1[BOARD_W-1:CELLS_W]};

    paz_move_calc u_calc (
        .board     (r_board),
        .dir       (r_dir),
        .new_board (w_new_board),
        .legal     (w_legal)
    );

    // Undo pops the last slot, so it only needs a non-empty history.
    assign w_depth_ok  = w_undo ? (r_depth != 5'd0) : (r_depth < C_MAX_DEPTH);
    assign w_depth_nxt = w_undo ? (r_depth - 5'd1) : (r_depth + 5'd1);
    assign w_slot      = w_undo ? (C_MOVE0 + r_depth - 5'd1) : (C_MOVE0 + r_depth);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_dir     <= '0;
            r_board   <= '0;
            r_depth   <= '0;
`ifdef PAZ_UNDO_EN
            r_undo    <= 1'b0;
`endif
            busy      <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            solved    <= 1'b0;
            depth_out <= '0;
            rf_src0   <= '0;
            rf_src1   <= '0;
            rf_dst    <= '0;
            rf_we     <= 1'b0;
            rf_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dir   <= dir;
`ifdef PAZ_UNDO_EN
                        r_undo  <= undo;
`endif
                        busy    <= 1'b1;
                        rf_src0 <= REG_BOARD;
                        rf_src1 <= REG_DEPTH;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_board <= rf_data0[CELLS_W-1:0];
                    r_depth <= rf_data1[4:0];
                    r_state <= S_CHK;
`ifdef PAZ_UNDO_EN
                    if (r_undo) begin
                        rf_src0 <= C_MOVE0 + rf_data1[4:0] - 5'd1;
                        r_state <= S_RD_M;
                    end
`endif
                end
`ifdef PAZ_UNDO_EN
                S_RD_M: begin
                    r_dir   <= rf_data0[1:0] ^ 2'b01;
                    r_state <= S_CHK;
                end
`endif
                S_CHK: begin
                    if (w_legal && w_depth_ok) begin
                        rf_dst   <= REG_BOARD;
                        rf_wdata <= {{(BOARD_W-CELLS_W){1'b0}}, w_new_board};
                        rf_we    <= 1'b1;
                        r_state  <= S_WR_B;
                    end else begin
                        done     <= 1'b1;
                        illegal  <= 1'b1;
                        r_state  <= S_FIN;
                    end
                end
                S_WR_B: begin
                    rf_dst   <= w_slot;
                    rf_wdata <= w_undo ? '0 : {24'b0, r_dir};
                    r_state  <= S_WR_M;
                end
                S_WR_M: begin
                    rf_dst   <= REG_DEPTH;
                    rf_wdata <= {21'b0, w_depth_nxt};
                    r_state  <= S_WR_D;
                end
                S_WR_D: begin
                    rf_we   <= 1'b0;
                    rf_src0 <= REG_BOARD;
                    rf_src1 <= REG_GOAL;
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    rf_dst   <= REG_COMP;
                    rf_wdata <= {25'b0, (rf_data0[CELLS_W-1:0] == rf_data1[CELLS_W-1:0])};
                    rf_we    <= 1'b1;
                    r_state  <= S_WR_C;
                end
                S_WR_C: begin
                    rf_we     <= 1'b0;
                    solved    <= rf_wdata[0];
                    depth_out <= w_depth_nxt;
                    done      <= 1'b1;
                    r_state   <= S_FIN;
                end
                S_FIN: begin
                    done    <= 1'b0;
                    illegal <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_paz_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_paz_move_ctrl
// Purpose  : Self-checking bench for paz_move_ctrl with a regfile and a
//            row/column puzzle reference model. Honours PAZ_UNDO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paz_move_ctrl;

    localparam int MAX_DEPTH = 19;
    localparam int MOVE0     = 6;
    localparam logic [25:0] GOAL   = 26'b000_001_010_011_100_101;
    localparam logic [25:0] BOARD2 = 26'b100_010_001_011_101_000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  dir   = 2'b00;
`ifdef PAZ_UNDO_EN
    logic        undo  = 1'b0;
`endif
    logic        busy, done, illegal, solved, rf_we;
    logic [4:0]  depth_out, rf_src0, rf_src1, rf_dst;
    logic [25:0] rf_wdata, rf_data0, rf_data1;

    logic [25:0] rf [32];
    logic [25:0] m  [32];
    logic        bd_we   = 1'b0;
    logic [4:0]  bd_addr = '0;
    logic [25:0] bd_data = '0;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_we  = 0;
    logic        exp_solved    = 1'b0;
    logic [4:0]  exp_depth_out = '0;

    paz_move_ctrl #(.MAX_DEPTH(MAX_DEPTH), .MOVE0(MOVE0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dir       (dir),
`ifdef PAZ_UNDO_EN
        .undo      (undo),
`endif
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .solved    (solved),
        .depth_out (depth_out),
        .rf_src0   (rf_src0),
        .rf_src1   (rf_src1),
        .rf_dst    (rf_dst),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .rf_data0  (rf_data0),
        .rf_data1  (rf_data1)
    );

    always #5 clk = ~clk;

    assign rf_data0 = rf[rf_src0];
    assign rf_data1 = rf[rf_src1];

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_dst] <= rf_wdata;
            n_we       <= n_we + 1;
        end else if (bd_we) begin
            rf[bd_addr] <= bd_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bd_write(input logic [4:0] a, input logic [25:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        m[a]    = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // Reference: blank moves on a 2-row x 3-column grid.
    function automatic logic model_move(input logic [17:0] b, input logic [1:0] d,
                                        output logic [17:0] nb);
        int   c [6];
        int   nblank = 0;
        int   pos = 0;
        int   row, col, tgt;
        logic ok;
        for (int i = 0; i < 6; i++) begin
            c[i] = int'(b[3*i +: 3]);
            if (c[i] == 0) begin
                nblank++;
                pos = i;
            end
        end
        row = pos / 3;
        col = pos % 3;
        case (d)
            2'b00:   begin ok = (row == 1); tgt = pos - 3; end
            2'b01:   begin ok = (row == 0); tgt = pos + 3; end
            2'b10:   begin ok = (col != 0); tgt = pos - 1; end
            default: begin ok = (col != 2); tgt = pos + 1; end
        endcase
        ok = ok && (nblank == 1);
        nb = b;
        if (ok) begin
            c[pos] = c[tgt];
            c[tgt] = 0;
            for (int i = 0; i < 6; i++) nb[3*i +: 3] = 3'(c[i]);
        end
        return ok;
    endfunction

    task automatic compare_image();
        int bad = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== m[i]) bad++;
        check_eq("rf_image", bad, 0);
    endtask

    task automatic run_req(input logic [1:0] d, input logic u, input logic inject);
        logic [4:0]  dep, slot, ndep;
        logic [1:0]  md;
        logic [17:0] nb;
        logic        ok, mv_ok, eq;
        int          lat_exp, k, we0;
        dep = m[2][4:0];
        md  = d;
        if (u) begin
            slot = 5'(MOVE0) + dep - 5'd1;
            md   = m[slot][1:0] ^ 2'b01;
            ok   = (dep != 5'd0);
            ndep = dep - 5'd1;
        end else begin
            slot = 5'(MOVE0) + dep;
            ok   = (int'(dep) < MAX_DEPTH);
            ndep = dep + 5'd1;
        end
        mv_ok   = model_move(m[0][17:0], md, nb);
        ok      = ok && mv_ok;
        lat_exp = ok ? (u ? 8 : 7) : (u ? 3 : 2);
        we0     = n_we;

        @(negedge clk);
        start = 1'b1;
        dir   = d;
`ifdef PAZ_UNDO_EN
        undo  = u;
`endif
        @(negedge clk);
        start = 1'b0;
        k     = 1;
        while (!done && k < 40) begin
            start = inject && (k == 2);
            if (start) dir = 2'($urandom_range(0, 3));
            @(negedge clk);
            k++;
        end
        check_eq("done_latency", k - 1, lat_exp);
        check_eq("illegal", {31'b0, illegal}, {31'b0, !ok});
        check_eq("busy_at_done", {31'b0, busy}, 1);
        start = inject;
        @(negedge clk);
        start = 1'b0;
        check_eq("done_single", {31'b0, done}, 0);
        check_eq("busy_after", {31'b0, busy}, 0);

        if (ok) begin
            eq            = (nb == m[1][17:0]);
            m[0]          = {8'b0, nb};
            m[slot]       = u ? 26'b0 : {24'b0, d};
            m[2]          = {21'b0, ndep};
            m[30]         = {25'b0, eq};
            exp_solved    = eq;
            exp_depth_out = ndep;
        end
        check_eq("write_count", n_we - we0, ok ? 4 : 0);
        check_eq("reg_board", rf[0], m[0]);
        check_eq("reg_depth", rf[2], m[2]);
        check_eq("reg_move", rf[slot], m[slot]);
        check_eq("reg_comp", rf[30], m[30]);
        check_eq("solved", {31'b0, solved}, {31'b0, exp_solved});
        check_eq("depth_out", {27'b0, depth_out}, {27'b0, exp_depth_out});
        compare_image();
    endtask

    task automatic load(input logic [25:0] b, input logic [4:0] dep);
        bd_write(5'd0, b);
        bd_write(5'd2, {21'b0, dep});
    endtask

    initial begin
        logic [25:0] b;
        int          p [6];
        int          j, t;
        logic        u;

        for (int i = 0; i < 32; i++) bd_write(5'(i), 26'b0);
        check_eq("rst_busy", {31'b0, busy}, 0);
        check_eq("rst_done", {31'b0, done}, 0);
        check_eq("rst_illegal", {31'b0, illegal}, 0);
        check_eq("rst_solved", {31'b0, solved}, 0);
        check_eq("rst_we", {31'b0, rf_we}, 0);
        check_eq("rst_depth_out", {27'b0, depth_out}, 0);
        check_eq("rst_outs", {rf_src0, rf_src1, rf_dst}, 0);
        check_eq("rst_wdata", rf_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bd_write(5'd1, GOAL);

        // Reset asserted while the move record is being written.
        load(BOARD2, 5'd0);
        @(negedge clk);
        start = 1'b1;
        dir   = 2'b01;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("wrm_we", {31'b0, rf_we}, 1);
        check_eq("wrm_dst", {27'b0, rf_dst}, MOVE0);
        rst_n = 1'b0;
        #1;
        check_eq("abort_we", {31'b0, rf_we}, 0);
        check_eq("abort_busy", {31'b0, busy}, 0);
        check_eq("abort_outs", {rf_src0, rf_src1, rf_dst}, 0);
        check_eq("abort_wdata", rf_wdata, 0);
        m[0] = 26'b100_010_000_011_101_001;
        exp_solved    = 1'b0;
        exp_depth_out = '0;
        @(negedge clk);
        compare_image();
        rst_n = 1'b1;
        run_req(2'b10, 1'b0, 1'b0);

        load(BOARD2, 5'd0);
        run_req(2'b01, 1'b0, 1'b1);
        check_eq("t2_board", rf[0], 26'b100_010_000_011_101_001);
        check_eq("t2_move", rf[6], 26'b01);
        check_eq("t2_depth", rf[2], 26'd1);
        check_eq("t2_comp", rf[30], 26'd0);
`ifdef PAZ_UNDO_EN
        run_req(2'b00, 1'b1, 1'b0);
        check_eq("undo_board", rf[0], BOARD2);
        check_eq("undo_depth", rf[2], 26'd0);
        check_eq("undo_slot", rf[6], 26'd0);
`endif

        load(BOARD2, 5'd0);
        run_req(2'b00, 1'b0, 1'b0);
        check_eq("t3_board", rf[0], BOARD2);

        load(GOAL, 5'd0);
        for (int i = 0; i < MAX_DEPTH; i++) begin
            run_req((i % 2 == 0) ? 2'b10 : 2'b11, 1'b0, (i % 5) == 3);
            if (i == 0) check_eq("t4_first", rf[0], 26'b001_000_010_011_100_101);
            if (i == 1) begin
                check_eq("t4_goal", rf[0], GOAL);
                check_eq("t4_depth", rf[2], 26'd2);
                check_eq("t4_move", rf[7], 26'b11);
                check_eq("t4_comp", rf[30], 26'd1);
                check_eq("t4_solved", {31'b0, solved}, 1);
            end
        end
        check_eq("t5_depth_out", {27'b0, depth_out}, MAX_DEPTH);
        run_req(2'b10, 1'b0, 1'b0);
        check_eq("t5_depth_reg", rf[2], MAX_DEPTH);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 6; i++) p[i] = i;
                for (int i = 5; i > 0; i--) begin
                    j    = $urandom_range(0, i);
                    t    = p[i];
                    p[i] = p[j];
                    p[j] = t;
                end
                b = '0;
                for (int i = 0; i < 6; i++) begin
                    if ($urandom_range(0, 9) < 2) b[3*i +: 3] = 3'($urandom_range(0, 7));
                    else                          b[3*i +: 3] = 3'(p[i]);
                end
                load(b, 5'($urandom_range(0, 20)));
                if ($urandom_range(0, 3) == 0) bd_write(5'd1, b);
            end
            u = 1'b0;
`ifdef PAZ_UNDO_EN
            u = ($urandom_range(0, 2) == 0);
`endif
            run_req(2'($urandom_range(0, 3)), u, $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
